// File: rtl/regfile_dump_reader.sv
// Walks a register-file read port from FIRST_REG to LAST_REG and streams each
// word out over a valid/ready handshake, pulsing done after the last word.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rr_addr,
  input  logic [31:0] rr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_rr_addr;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_index;

  // State register; busy/done are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; abort only matters while a word is being fetched or sent
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (out_ready) begin
          if (r_out_index == LAST_A) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_ADDR;
          end
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_next_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
      S_ADDR, S_SEND: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
      end
      S_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Address counter and output word; the counter stops at LAST_REG and never wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_addr   <= FIRST_A;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_index <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rr_addr   <= FIRST_A;
          r_out_valid <= 1'b0;
        end
        S_ADDR: begin
          if (abort) begin
            r_rr_addr   <= FIRST_A;
            r_out_valid <= 1'b0;
          end else begin
            r_out_data  <= rr_data;
            r_out_index <= r_rr_addr;
            r_out_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_rr_addr   <= FIRST_A;
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_index != LAST_A) begin
              r_rr_addr <= r_rr_addr + 5'd1;
            end else begin
              r_rr_addr <= r_rr_addr;
            end
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        S_DONE: begin
          r_rr_addr   <= FIRST_A;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_rr_addr   <= FIRST_A;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rr_addr   = r_rr_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized scoreboard bench for regfile_dump_reader: a full-range instance
// checked against expected word/done queues, plus a single-register window instance.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  rr_addr, out_index;
  logic [31:0] rr_data, out_data;
  logic        out_valid, busy, done;

  logic        start_w;
  logic [4:0]  rr_addr_w, out_index_w;
  logic [31:0] rr_data_w, out_data_w;
  logic        out_valid_w, busy_w, done_w;

  logic [31:0] regs   [32];
  logic [31:0] regs_w [32];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int          rel;
  } exp_t;

  exp_t q[$];
  int   done_q[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit          prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx, prev_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rr_data   = regs[rr_addr];
  assign rr_data_w = regs_w[rr_addr_w];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rr_addr(rr_addr), .rr_data(rr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(2)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .abort(1'b0),
    .rr_addr(rr_addr_w), .rr_data(rr_data_w),
    .out_valid(out_valid_w), .out_ready(1'b1),
    .out_data(out_data_w), .out_index(out_index_w),
    .busy(busy_w), .done(done_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and every done pulse
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_index", 32'(out_index), 32'(prev_idx));
        chk("hold_rr_addr", 32'(rr_addr), 32'(prev_addr));
      end
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got index %0d, expected no word", out_index);
        end else begin
          e = q.pop_front();
          chk("word_index", 32'(out_index), 32'(e.idx));
          chk("word_data", out_data, e.data);
          if (e.rel >= 0) chk("word_cycle", 32'(cyc - start_cyc), 32'(e.rel));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_done: got done at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          if (d >= 0) chk("done_cycle", 32'(cyc - start_cyc), 32'(d));
        end
      end
      prev_hold = out_valid && !out_ready && !abort;
      prev_data = out_data;
      prev_idx  = out_index;
      prev_addr = rr_addr;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_index"}, 32'(out_index), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rr_addr"}, 32'(rr_addr), 32'd0);
  endtask

  // One dump: ab_w/rs_w pick the word that gets aborted/reset, st_w the stalled word
  task automatic run_dump(input bit pat, input bit rnd_ready, input int ab_w, input int rs_w,
                          input int st_w, input int st_len, input bit ab_start, input bit timed);
    int  stop_w;
    int  n_stall;
    bit  fin;
    for (int i = 0; i < 32; i++) regs[i] = pat ? (32'hA5A5_0000 + 32'(i)) : $urandom;
    stop_w = (ab_w >= 0) ? ab_w : ((rs_w >= 0) ? rs_w : 32);
    for (int i = 0; i < stop_w; i++) q.push_back('{5'(i), regs[i], timed ? (2 + 2 * i) : -1});
    if (stop_w == 32) done_q.push_back(timed ? 65 : -1);

    @(posedge clk); #1;
    start = 1'b1; abort = ab_start; out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start_cyc = cyc;
    fin = 1'b0; n_stall = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      if (done) begin
        abort = 1'b1;
        fin = 1'b1;
      end else if (out_valid && ab_w >= 0 && 32'(out_index) == 32'(ab_w)) begin
        abort = 1'b1; out_ready = 1'b1; fin = 1'b1;
      end else if (out_valid && rs_w >= 0 && 32'(out_index) == 32'(rs_w)) begin
        reset = 1'b1; out_ready = 1'b1; fin = 1'b1;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && st_w >= 0 && 32'(out_index) == 32'(st_w) && n_stall < st_len) begin
          out_ready = 1'b0;
          n_stall++;
        end
        if (busy && rnd_ready) start = 1'($urandom_range(0, 1));
      end
    end
    if (!fin) chk("dump_timeout", 32'd0, 32'd1);

    @(posedge clk); #1;
    if (rs_w >= 0) begin
      chk_reset_outputs("mid_reset");
      reset = 1'b0;
    end else begin
      chk("after_valid", 32'(out_valid), 32'd0);
      chk("after_busy", 32'(busy), 32'd0);
      chk("after_done", 32'(done), 32'd0);
      chk("after_rr_addr", 32'(rr_addr), 32'd0);
    end
    abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (st_len > 0) chk("stall_len", 32'(n_stall), 32'(st_len));
    chk("words_left", 32'(q.size()), 32'd0);
    chk("done_left", 32'(done_q.size()), 32'd0);
    q.delete();
    done_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; start_w = 1'b0;
    for (int i = 0; i < 32; i++) begin
      regs[i]   = 32'd0;
      regs_w[i] = $urandom;
    end
    regs_w[2] = 32'h9863_5533;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_w_rr_addr", 32'(rr_addr_w), 32'd2);
    reset = 1'b0;

    run_dump(1'b1, 1'b0, -1, -1, -1, 0, 1'b0, 1'b1);
    run_dump(1'b1, 1'b0, -1, -1, 3, 5, 1'b0, 1'b0);
    run_dump(1'b0, 1'b1, -1, -1, -1, 0, 1'b1, 1'b0);
    run_dump(1'b0, 1'b0, 10, -1, -1, 0, 1'b0, 1'b0);
    run_dump(1'b0, 1'b0, -1, -1, -1, 0, 1'b0, 1'b1);
    run_dump(1'b0, 1'b1, -1, 5, -1, 0, 1'b0, 1'b0);
    for (int it = 0; it < 3; it++) begin
      run_dump(1'b0, 1'b1, -1, -1, int'($urandom_range(0, 31)), 3, 1'b0, 1'b0);
    end

    // Single-register window: word in cycle 2, done in cycle 3
    @(posedge clk); #1;
    start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    chk("win_c1_busy", 32'(busy_w), 32'd1);
    chk("win_c1_rr_addr", 32'(rr_addr_w), 32'd2);
    chk("win_c1_valid", 32'(out_valid_w), 32'd0);
    @(posedge clk); #1;
    chk("win_c2_valid", 32'(out_valid_w), 32'd1);
    chk("win_c2_index", 32'(out_index_w), 32'd2);
    chk("win_c2_data", out_data_w, 32'h9863_5533);
    chk("win_c2_done", 32'(done_w), 32'd0);
    @(posedge clk); #1;
    chk("win_c3_valid", 32'(out_valid_w), 32'd0);
    chk("win_c3_done", 32'(done_w), 32'd1);
    chk("win_c3_busy", 32'(busy_w), 32'd0);
    @(posedge clk); #1;
    chk("win_c4_done", 32'(done_w), 32'd0);
    chk("win_c4_busy", 32'(busy_w), 32'd0);
    chk("win_c4_rr_addr", 32'(rr_addr_w), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0: first register index dumped (0..31).
REQ-002 The block SHALL have parameter LAST_REG, default 31: last register index dumped (FIRST_REG..31).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  dump request, sampled only in IDLE.
REQ-006 The block SHALL have port abort  input  1  synchronous cancel of a dump in progress.
REQ-007 The block SHALL have port rr_addr  output  5  read-register address driven to the register file read port.
REQ-008 The block SHALL have port rr_data  input  32  combinational read data returned by the register file for rr_addr.
REQ-009 The block SHALL have port out_valid  output  1  out_data/out_index hold a valid word.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-011 The block SHALL have port out_data  output  32  captured register contents.
REQ-012 The block SHALL have port out_index  output  5  register index of out_data.
REQ-013 The block SHALL have port busy  output  1  high in ADDR and SEND states.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 The FSM SHALL have four states: IDLE, ADDR, SEND and DONE.
REQ-016 In IDLE with start=1, the FSM SHALL go to ADDR next cycle with rr_addr=FIRST_REG; start in any other state SHALL be ignored.
REQ-017 In ADDR, the block SHALL register out_data<=rr_data, out_index<=rr_addr and out_valid<=1, and SHALL go to SEND.
REQ-018 In SEND, out_valid, out_data, out_index and rr_addr SHALL hold stable while out_ready=0.
REQ-019 In SEND with out_ready=1, out_valid SHALL clear next cycle; if out_index==LAST_REG the FSM SHALL go to DONE, else rr_addr SHALL increment by 1 and the FSM SHALL go to ADDR.
REQ-020 The address counter SHALL never wrap: at LAST_REG=31 no increment occurs, and rr_addr SHALL be reloaded with FIRST_REG on entry to IDLE.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the FSM SHALL go to IDLE.
REQ-022 Throughput SHALL be one word per 2 cycles with out_ready held at 1: word k (k=0..N-1, N=LAST_REG-FIRST_REG+1) is valid in cycle 2+2k after the start cycle (cycle 0); done SHALL be high in cycle 2N+1.
REQ-023 With abort=1 in ADDR or SEND, the FSM SHALL go to IDLE next cycle with out_valid=0 and no done pulse, even if the handshake completes in that same cycle.
REQ-024 abort in IDLE or DONE SHALL have no effect; a DONE pulse SHALL still complete.
REQ-025 With FIRST_REG==LAST_REG, exactly one word SHALL be emitted, followed by done.
REQ-026 The block SHALL never write the register file; it SHALL only drive the read address.

Reset
REQ-027 With reset=1 at a clock edge, the state SHALL become IDLE with rr_addr=FIRST_REG, out_valid=0, out_data=0, out_index=0, busy=0 and done=0.
REQ-028 Reset SHALL have priority over start, abort and the handshake; reset mid-dump SHALL drop the current word without a done pulse.

Verification
REQ-029 Full dump: preload regs with r[i]=32'hA5A50000+i, pulse start, out_ready=1 -> 32 words with index 0..31 and matching data; valid in cycles 2,4,...,64; done in cycle 65.
REQ-030 Backpressure: out_ready=0 for 5 cycles on word 3 -> out_valid, out_data=32'hA5A50003 and out_index=3 stable; word 3 accepted once; no word skipped or duplicated.
REQ-031 Window: FIRST_REG=2, LAST_REG=2, r2=32'h98635533 -> single word (2, 32'h98635533); done 3 cycles after start.
REQ-032 Abort: abort=1 during SEND of word 10, with out_ready=1 in the same cycle -> next cycle IDLE, out_valid=0, no done; a new start restarts at index 0.
REQ-033 Reset mid-dump: reset=1 at word 5 -> all outputs at reset values next cycle; start asserted while busy -> no effect.
